// File: rtl/pipelined_mul_acc_pkg.sv
// Shared definitions for pipelined_mul_acc: pipeline depth bounds, the
// record carried between stages, and the saturation limit helpers used
// when the MUL_ACC_SATURATE_EN build option is enabled.
package pipelined_mul_acc_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;

  // Product storage is sized for the widest supported operand pair; the
  // full product (DIN0_WIDTH+DIN1_WIDTH) must stay below this width.
  localparam int PROD_MAX_W = 128;

  // Two guard bits so acc + product never overflows before clamping.
  localparam int SUM_W = PROD_MAX_W + 2;

  typedef struct packed {
    logic                  vld;
    logic                  sgn;
    logic                  first;
    logic [PROD_MAX_W-1:0] product;  // already sign/zero extended
  } stage_rec_t;

  // Largest value representable in w bits for the given signedness.
  function automatic logic signed [SUM_W-1:0] sat_hi(input int unsigned w, input logic sgn);
    logic signed [SUM_W-1:0] one;
    one = SUM_W'(1);
    if (sgn) return (one <<< (w - 1)) - one;
    else     return (one <<< w) - one;
  endfunction

  // Smallest value representable in w bits for the given signedness.
  function automatic logic signed [SUM_W-1:0] sat_lo(input int unsigned w, input logic sgn);
    logic signed [SUM_W-1:0] one;
    one = SUM_W'(1);
    if (sgn) return -(one <<< (w - 1));
    else     return '0;
  endfunction

endpackage

// File: rtl/pipelined_mul_acc_if.sv
// Operand/result handshake bundle for pipelined_mul_acc.
// master: the side that supplies operands and consumes results.
// slave : the multiply-accumulate block itself.
interface pipelined_mul_acc_if #(
  parameter int DIN0_WIDTH = 24,
  parameter int DIN1_WIDTH = 41,
  parameter int DOUT_WIDTH = 64
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  in_signed;
  logic                  in_first;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  out_sat;

  modport master (
    output in_valid, din0, din1, in_signed, in_first, out_ready,
    input  in_ready, out_valid, dout, out_sat
  );

  modport slave (
    input  in_valid, din0, din1, in_signed, in_first, out_ready,
    output in_ready, out_valid, dout, out_sat
  );

endinterface

// File: rtl/pipelined_mul_acc_stage.sv
// mul_acc_stage: one stallable register slice of the multiply pipeline.
// The valid bit is reset; the payload is not, since it is only ever
// observed alongside a set valid bit.
module mul_acc_stage
  import pipelined_mul_acc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  stage_rec_t rec_in,
  output stage_rec_t rec_q
);

  logic                  vld_d, vld_q;
  logic                  sgn_d, sgn_q;
  logic                  first_d, first_q;
  logic [PROD_MAX_W-1:0] product_d, product_q;

  // Load the upstream record when the pipeline advances, otherwise hold.
  always_comb begin
    vld_d     = vld_q;
    sgn_d     = sgn_q;
    first_d   = first_q;
    product_d = product_q;
    if (advance) begin
      vld_d     = rec_in.vld;
      sgn_d     = rec_in.sgn;
      first_d   = rec_in.first;
      product_d = rec_in.product;
    end
  end

  // Valid bit: cleared by reset so in-flight beats are discarded.
  always_ff @(posedge clk) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_d;
  end

  // Payload: no reset needed.
  always_ff @(posedge clk) begin
    sgn_q     <= sgn_d;
    first_q   <= first_d;
    product_q <= product_d;
  end

  // Repack the slice contents for the next stage.
  always_comb begin
    rec_q.vld     = vld_q;
    rec_q.sgn     = sgn_q;
    rec_q.first   = first_q;
    rec_q.product = product_q;
  end

endmodule

// File: rtl/pipelined_mul_acc.sv
// pipelined_mul_acc: pipelined multiplier with running-sum accumulator.
// Products are formed combinationally from the accepted beat, carried
// through NUM_STAGE-1 mul_acc_stage slices, then summed into the output
// register. Define MUL_ACC_SATURATE_EN to clamp sums to the DOUT_WIDTH
// range (flagged on out_sat); otherwise sums wrap and out_sat stays 0.
module pipelined_mul_acc
  import pipelined_mul_acc_pkg::*;
#(
  parameter int DIN0_WIDTH = 24,
  parameter int DIN1_WIDTH = 41,
  parameter int DOUT_WIDTH = 64,
  parameter int NUM_STAGE  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  pipelined_mul_acc_if.slave bus
);

  localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LAST   = NUM_STAGE - 1;

  logic stall, advance;

  logic                   out_valid_d, out_valid_q;
  logic [DOUT_WIDTH-1:0]  dout_d, dout_q;
  logic                   out_sat_d, out_sat_q;
  logic [DOUT_WIDTH-1:0]  acc_d, acc_q;

  logic [PROD_W-1:0]        prod_u_p0;
  logic signed [PROD_W-1:0] prod_s_p0;
  stage_rec_t               rec_p0;

  stage_rec_t stg [NUM_STAGE];
  stage_rec_t last_p;

  logic signed [SUM_W-1:0] acc_ext, prod_ext, sum_full;
  logic [DOUT_WIDTH-1:0]   sum_p;
  logic                    sum_sat;

  // A held result that downstream refuses freezes the whole pipeline.
  always_comb begin
    stall        = out_valid_q && !bus.out_ready;
    advance      = ce && !stall;
    bus.in_ready = advance && !reset;
  end

  // ---- stage p0: accept beat and form the full-width product ----
  always_comb begin
    prod_u_p0      = PROD_W'(bus.din0) * PROD_W'(bus.din1);
    prod_s_p0      = PROD_W'($signed(bus.din0)) * PROD_W'($signed(bus.din1));
    rec_p0.vld     = bus.in_valid && bus.in_ready;
    rec_p0.sgn     = bus.in_signed;
    rec_p0.first   = bus.in_first;
    if (bus.in_signed) rec_p0.product = PROD_MAX_W'(prod_s_p0);
    else               rec_p0.product = PROD_MAX_W'(prod_u_p0);
  end

  assign stg[0] = rec_p0;

  // ---- stages p1..p(NUM_STAGE-1): plain register slices ----
  for (genvar k = 1; k < NUM_STAGE; k++) begin : g_slice
    mul_acc_stage u_stage (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .rec_in  (stg[k-1]),
      .rec_q   (stg[k])
    );
  end

  assign last_p = stg[LAST];

  // ---- final stage: accumulate, then clamp or wrap ----
  // The accumulator is reinterpreted with the current beat's signedness so
  // mixed-sign sums follow each beat's own flag.
  always_comb begin
    if (last_p.sgn) acc_ext = SUM_W'($signed(acc_q));
    else            acc_ext = SUM_W'(acc_q);
    prod_ext = SUM_W'($signed(last_p.product));
    sum_full = last_p.first ? prod_ext : acc_ext + prod_ext;
`ifdef MUL_ACC_SATURATE_EN
    sum_p   = DOUT_WIDTH'(sum_full);
    sum_sat = 1'b0;
    if (sum_full > sat_hi(DOUT_WIDTH, last_p.sgn)) begin
      sum_p   = DOUT_WIDTH'(sat_hi(DOUT_WIDTH, last_p.sgn));
      sum_sat = 1'b1;
    end else if (sum_full < sat_lo(DOUT_WIDTH, last_p.sgn)) begin
      sum_p   = DOUT_WIDTH'(sat_lo(DOUT_WIDTH, last_p.sgn));
      sum_sat = 1'b1;
    end
`else
    sum_p   = DOUT_WIDTH'(sum_full);
    sum_sat = 1'b0;
`endif
  end

  // Output register and accumulator only move when a valid result enters.
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_sat_d   = out_sat_q;
    acc_d       = acc_q;
    if (advance) begin
      out_valid_d = last_p.vld;
      if (last_p.vld) begin
        dout_d    = sum_p;
        out_sat_d = sum_sat;
        acc_d     = sum_p;
      end
    end
  end

  // Result/accumulator state; reset wins over ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_sat_q   <= out_sat_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: doc/pipelined_mul_acc.md
PIPELINED_MUL_ACC -- requirements
Module: pipelined_mul_acc

Interface
REQ-001 Parameter DIN0_WIDTH, default 24, operand A width.
REQ-002 Parameter DIN1_WIDTH, default 41, operand B width.
REQ-003 Parameter DOUT_WIDTH, default 64, result/accumulator width; must be >= 2.
REQ-004 Parameter NUM_STAGE, default 2, pipeline latency in cycles; legal range 1..4.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ce  input  1  clock enable; when low, all state holds.
REQ-008 in_valid  input  1  operand beat valid.
REQ-009 in_ready  output  1  block accepts beat this cycle.
REQ-010 din0  input  DIN0_WIDTH  operand A.
REQ-011 din1  input  DIN1_WIDTH  operand B.
REQ-012 in_signed  input  1  1: operands two's complement; 0: zero-extended.
REQ-013 in_first  input  1  1: start new sum; 0: add to running sum.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 dout  output  DOUT_WIDTH  product or running sum.
REQ-017 out_sat  output  1  result was clamped (saturation build only).

Function
REQ-018 Beat accepted when in_valid && in_ready; in_ready = ce && !(out_valid && !out_ready).
REQ-019 Product = din0*din1 at full width DIN0_WIDTH+DIN1_WIDTH, sign- or zero-extended per in_signed, then truncated/extended to DOUT_WIDTH.
REQ-020 Accepted beat appears on dout with out_valid exactly NUM_STAGE ce-high, unstalled cycles later.
REQ-021 Per-stage valid bit travels with data; bubbles produce no output and never touch the accumulator.
REQ-022 Final stage: sum = in_first ? product : acc + product; acc updated to sum only when result enters the output register.
REQ-023 Stall: out_valid && !out_ready freezes every stage and acc; dout, out_sat stable until handshake.
REQ-024 Back-to-back beats sustain one result per cycle with out_ready held high.
REQ-025 ce low overrides all: no acceptance, no advance, outputs held; handshake counted only with ce high.
REQ-026 Beat with in_first=0 and no prior sum since reset accumulates onto acc reset value 0.
REQ-027 Mixed in_signed within one sum: each beat's own flag governs its product extension and saturation bounds.

Reset
REQ-028 reset high at clk edge (regardless of ce) clears all stage valids, acc, dout, out_valid, out_sat to 0.
REQ-029 Reset mid-operation discards in-flight beats; no result emitted for them.
REQ-030 in_ready = 0 while reset is high.

Configuration
REQ-031 Macro MUL_ACC_SATURATE_EN defined: sum clamped to DOUT_WIDTH range (signed or unsigned per beat), out_sat=1 on clamp.
REQ-032 Macro undefined: sum wraps modulo 2^DOUT_WIDTH, out_sat tied 0.

Structure
REQ-033 Shared package holds NUM_STAGE bounds, stage-record typedef (valid, signed, first, product) and saturation limit functions.
REQ-034 One sub-module, mul_acc_stage, a stallable register slice instantiated NUM_STAGE-1 times before the accumulate stage.

Verification
REQ-035 Unsigned, NUM_STAGE=2: din0=3, din1=5, first=1 at cycle 0 -> dout=15, out_valid at cycle 2.
REQ-036 Signed: din0=-2, din1=7, first=1 -> dout=-14 sign-extended to 64 bits.
REQ-037 Accumulate: beats (2,3,first=1),(4,5,0),(1,1,0) back-to-back -> dout 6, 26, 27 on consecutive cycles.
REQ-038 Stall: out_ready low 3 cycles with 2 beats in flight -> in_ready low, dout held, no loss, order preserved.
REQ-039 Overflow DOUT_WIDTH=8 unsigned: (16,16,1),(1,1,0) -> saturate build dout=255, out_sat=1; wrap build dout=1, out_sat=0.
REQ-040 Reset asserted with 2 beats in flight -> next cycle out_valid=0, acc=0; following (1,1,first=0) yields 1.
